// File: rtl/restador_serial.sv
// restador_serial: bit-serial N-bit subtractor computing a - b as a + ~b + 1,
// one bit per clock, LSB first, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    operand handshake (in_ready high only in IDLE)
//   a, b                  minuend and subtrahend (b is inverted internally)
//   out_valid, out_ready  result handshake (out_valid high only in DONE)
//   diff                  a - b modulo 2^N
//   borrow                1 when a < b unsigned (~carry_out)
//   overflow              signed overflow of the subtraction
//   zero                  1 when diff == 0
module restador_serial #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         overflow,
  output logic         zero
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    sa_q, sa_d;
  logic [N-1:0]    sb_q, sb_d;
  logic [N-1:0]    diff_q, diff_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            a_msb_q, a_msb_d;
  logic            b_msb_q, b_msb_d;
  logic            borrow_q, borrow_d;
  logic            overflow_q, overflow_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, out_valid_d;
  logic            sum_bit;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      borrow_q    <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      borrow_q    <= borrow_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and serial full-adder datapath
  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    borrow_d    = borrow_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    sum_bit     = sa_q[0] ^ sb_q[0] ^ carry_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = ~b;
          carry_d = 1'b1;  // the +1 of the two's complement negation
          cnt_d   = '0;
          diff_d  = '0;
          a_msb_d = a[N-1];
          b_msb_d = b[N-1];
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
        sa_d    = {1'b0, sa_q[N-1:1]};
        sb_d    = {1'b0, sb_q[N-1:1]};
        diff_d  = {sum_bit, diff_q[N-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          // Last bit: flags are taken from the completed difference
          state_d     = DONE;
          borrow_d    = ~carry_d;
          overflow_d  = (a_msb_q ^ b_msb_q) & (diff_d[N-1] ^ a_msb_q);
          zero_d      = (diff_d == '0);
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_restador_serial.sv
// Directed testbench for restador_serial with N = 4.
module tb_restador_serial;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         borrow;
  logic         overflow;
  logic         zero;

  int n_cmp = 0;
  int n_bad = 0;

  restador_serial #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: present an operand pair at a negedge, return at the negedge after the accept edge.
  task automatic drive_accept(input logic [N-1:0] av, input logic [N-1:0] bv);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if ({diff, borrow, overflow, zero} !== 7'b0) begin n_bad++;
      $display("FAIL reset_outputs got %b want 0000000", {diff, borrow, overflow, zero}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_accept(4'd5, 4'd3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== (k == 4)) begin n_bad++;
        $display("FAIL basic_latency cycle %0d got %b want %b", k, out_valid, (k == 4)); end
    end
    n_cmp++; if ({diff, borrow, overflow, zero} !== {4'b0010, 3'b000}) begin n_bad++;
      $display("FAIL basic_result got %b want 0010000", {diff, borrow, overflow, zero}); end
    @(negedge clk);
    n_cmp++; if ({out_valid, in_ready, diff} !== {2'b01, 4'b0010}) begin n_bad++;
      $display("FAIL basic_return got %b want 010010", {out_valid, in_ready, diff}); end
  endtask

  task automatic test_borrow();
    out_ready = 1'b1;
    drive_accept(4'd3, 4'd5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== (k == 4) ? 1'b0 : 1'b0) begin n_bad++;
        $display("FAIL borrow_in_ready cycle %0d got %b want 0", k, in_ready); end
    end
    n_cmp++; if ({out_valid, diff, borrow, overflow, zero} !== {1'b1, 4'b1110, 3'b100}) begin n_bad++;
      $display("FAIL borrow_result got %b want 11110100", {out_valid, diff, borrow, overflow, zero}); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    drive_accept(4'b0111, 4'b1000);
    repeat (4) @(negedge clk);
    n_cmp++; if ({out_valid, diff, borrow, overflow, zero} !== {1'b1, 4'b1111, 3'b110}) begin n_bad++;
      $display("FAIL overflow_result got %b want 11111110", {out_valid, diff, borrow, overflow, zero}); end
    @(negedge clk);
  endtask

  task automatic test_zero_and_input_change();
    out_ready = 1'b1;
    drive_accept(4'd9, 4'd9);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      // Scribble over the operands while busy; only sampled in IDLE.
      a        = 4'(k * 3 + 1);
      b        = 4'(k * 5 + 2);
      in_valid = (k < 4);
    end
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, diff, borrow, overflow, zero} !== {1'b1, 4'b0000, 3'b001}) begin n_bad++;
      $display("FAIL zero_result got %b want 10000001", {out_valid, diff, borrow, overflow, zero}); end
    @(negedge clk);
    n_cmp++; if ({out_valid, in_ready, zero} !== 3'b011) begin n_bad++;
      $display("FAIL zero_return got %b want 011", {out_valid, in_ready, zero}); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_accept(4'd12, 4'd4);
    repeat (4) @(negedge clk);
    n_cmp++; if ({out_valid, diff, borrow, overflow, zero} !== {1'b1, 4'b1000, 3'b000}) begin n_bad++;
      $display("FAIL bp_result got %b want 11000000", {out_valid, diff, borrow, overflow, zero}); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++; if ({out_valid, in_ready, diff} !== {2'b10, 4'b1000}) begin n_bad++;
        $display("FAIL bp_hold cycle %0d got %b want 101000", k, {out_valid, in_ready, diff}); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({out_valid, in_ready, diff} !== {2'b01, 4'b1000}) begin n_bad++;
      $display("FAIL bp_release got %b want 011000", {out_valid, in_ready, diff}); end
    drive_accept(4'd1, 4'd2);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_new_accept in_ready got %b want 0", in_ready); end
    repeat (4) @(negedge clk);
    n_cmp++; if ({out_valid, diff, borrow, overflow, zero} !== {1'b1, 4'b1111, 3'b100}) begin n_bad++;
      $display("FAIL bp_next_result got %b want 11111100", {out_valid, diff, borrow, overflow, zero}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int seen_valid;
    out_ready = 1'b1;
    drive_accept(4'd6, 4'd1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, in_ready, diff, borrow, overflow, zero} !== {2'b01, 4'b0000, 3'b000}) begin n_bad++;
      $display("FAIL rst_mid_clear got %b want 010000000", {out_valid, in_ready, diff, borrow, overflow, zero}); end
    seen_valid = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen_valid++;
    end
    n_cmp++; if (seen_valid !== 0) begin n_bad++;
      $display("FAIL rst_mid_no_pulse got %0d valid cycles want 0", seen_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    drive_accept(4'd2, 4'd1);
    repeat (4) @(negedge clk);
    n_cmp++; if ({out_valid, diff, borrow, overflow, zero} !== {1'b1, 4'b0001, 3'b000}) begin n_bad++;
      $display("FAIL rst_mid_after got %b want 10001000", {out_valid, diff, borrow, overflow, zero}); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_zero_and_input_change();
    test_backpressure();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
